rock_field_mgr: RTL

Parametrised successor to the two-slot rock manager. Owns N_ROCKS asteroid slots and spawns new rocks on a programmable period from an internal 16-bit Fibonacci LFSR. Moves every live rock once per frame tick, wrapping at the screen edges, and retires rocks on a per-slot kill from the collision detector. Sits between the collision detector (kill inputs) and the pixel mixer (per-rock pixel hits).

---
 rtl/rock_field_mgr.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rock_field_mgr.sv
// Asteroid slot manager: LFSR-driven spawning, per-frame motion with screen wrap, kills, pixel hits.
// Optional macro ROCK_ALLOC_ROUNDROBIN_EN selects round-robin slot allocation instead of lowest-index.
module rock_field_mgr #(
  parameter int          N_ROCKS      = 8,
  parameter int          SPAWN_PERIOD = 120,
  parameter logic [15:0] LFSR_SEED    = 16'h2121,
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          ROCK_SIZE    = 16
) (
  input  logic               clk60hz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [9:0]         px,
  input  logic [9:0]         py,
  input  logic [N_ROCKS-1:0] kill,
  output logic [N_ROCKS-1:0] pixel,
  output logic [N_ROCKS-1:0] in_use,
  output logic               spawn_drop,
  output logic [4:0]         alive_count
);

  localparam int          CW  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int          SW  = (N_ROCKS > 1) ? $clog2(N_ROCKS) : 1;
  localparam logic [10:0] W11 = 11'(SCREEN_W);
  localparam logic [10:0] H11 = 11'(SCREEN_H);
  localparam logic [10:0] S11 = 11'(ROCK_SIZE);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] dx;  // two's complement velocity
    logic [2:0] dy;
  } rock_t;

  logic [15:0]        lfsr;
  logic [CW-1:0]      spawn_cnt;
  rock_t              rock [N_ROCKS];
  rock_t              new_rock;
  logic               attempt;
  logic               found;
  logic [SW-1:0]      alloc_idx;
  logic [N_ROCKS-1:0] alloc_mask;
  logic [N_ROCKS-1:0] in_use_d;
  logic [4:0]         alive_d;

  function automatic logic [9:0] wrap(input logic [9:0] v, input logic [2:0] d,
                                      input logic [10:0] m);
    logic signed [10:0] s;
    s = $signed({1'b0, v}) + $signed({{8{d[2]}}, d});
    if (s < 0)                   s = s + $signed(m);
    else if (s >= $signed(m))    s = s - $signed(m);
    return s[9:0];
  endfunction

  assign attempt = enable && (spawn_cnt == CW'(SPAWN_PERIOD - 1));

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    new_rock    = '0;
    new_rock.x  = lfsr[9:0];
    if ({1'b0, lfsr[9:0]} >= W11) new_rock.x = lfsr[9:0] - W11[9:0];
    new_rock.y  = {1'b0, lfsr[8:0]};
    if ({2'b00, lfsr[8:0]} >= H11) new_rock.y = {1'b0, lfsr[8:0]} - H11[9:0];
    new_rock.dx = lfsr[12:10];
    new_rock.dy = lfsr[15:13];
    if (new_rock.dx == 3'd0 && new_rock.dy == 3'd0) new_rock.dx = 3'd1;
  end

`ifdef ROCK_ALLOC_ROUNDROBIN_EN
  logic [SW-1:0] last_alloc;

  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    alloc_idx = '0;
    for (int k = 0; k < N_ROCKS; k++) begin
      idx = (int'(last_alloc) + 1 + k) % N_ROCKS;
      if (!found && !in_use[idx]) begin
        found     = 1'b1;
        alloc_idx = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk60hz or negedge reset_n) begin
    if (!reset_n)             last_alloc <= SW'(N_ROCKS - 1);
    else if (attempt && found) last_alloc <= alloc_idx;
  end
`else
  always_comb begin
    found     = 1'b0;
    alloc_idx = '0;
    for (int i = 0; i < N_ROCKS; i++) begin
      if (!found && !in_use[i]) begin
        found     = 1'b1;
        alloc_idx = SW'(i);
      end
    end
  end
`endif

  // Allocation reads pre-edge in_use, so a slot killed this edge is not reusable until the next attempt.
  always_comb begin
    alloc_mask = '0;
    if (attempt && found) alloc_mask[alloc_idx] = 1'b1;
    in_use_d = (in_use & ~kill) | alloc_mask;
    alive_d  = '0;
    for (int i = 0; i < N_ROCKS; i++) alive_d = alive_d + 5'(in_use_d[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk60hz or negedge reset_n) begin
    if (!reset_n) begin
      lfsr        <= LFSR_SEED;
      spawn_cnt   <= '0;
      in_use      <= '0;
      alive_count <= '0;
      spawn_drop  <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr[10] ^ lfsr[12] ^ lfsr[13] ^ lfsr[15]};
      in_use      <= in_use_d;
      alive_count <= alive_d;
      spawn_drop  <= attempt && !found;
      if (enable) spawn_cnt <= attempt ? '0 : spawn_cnt + CW'(1);
    end
  end

  // NOTE: slot registers are discrete flops, not RAM, so they take the reset like any other state.
  always_ff @(posedge clk60hz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ROCKS; i++) rock[i] <= '0;
    end else begin
      for (int i = 0; i < N_ROCKS; i++) begin
        if (alloc_mask[i]) begin
          rock[i] <= new_rock;
        end else if (enable && in_use[i] && !kill[i]) begin
          rock[i].x <= wrap(rock[i].x, rock[i].dx, W11);
          rock[i].y <= wrap(rock[i].y, rock[i].dy, H11);
        end
      end
    end
  end

  // Unwrapped box test: rocks straddling an edge are clipped rather than split.
  always_comb begin
    pixel = '0;
    for (int i = 0; i < N_ROCKS; i++) begin
      pixel[i] = in_use[i]
               && ({1'b0, px} >= {1'b0, rock[i].x}) && ({1'b0, px} < {1'b0, rock[i].x} + S11)
               && ({1'b0, py} >= {1'b0, rock[i].y}) && ({1'b0, py} < {1'b0, rock[i].y} + S11);
    end
  end

endmodule
